// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and default starvation limit for the
// instruction/data memory arbiter.
package mem_arb_pkg;
  localparam int DW             = 16;
  localparam int AW             = 16;
  localparam int STARVE_LIM_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_e;
endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I fetch / D load-store) arbiter for one single-ported memory.
// D wins contention unless I has already lost STARVE_LIM times in a row.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_grant,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_grant,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   i_req_cnt,
  output logic [15:0]   d_req_cnt
);
  localparam logic [15:0] WAIT_LIM = 16'(STARVE_LIM);

  arb_state_e    state_q, state_d;
  logic [15:0]   i_wait_q, i_wait_d;
  logic          i_grant_q, i_grant_d, d_grant_q, d_grant_d;
  logic          i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_ack;

  // mem_en_q marks the command cycle; a completion there is not yet real
  assign mem_ack = mem_done && !mem_en_q;

  always_comb begin
    state_d     = state_q;
    i_wait_d    = i_wait_q;
    i_grant_d   = 1'b0;
    d_grant_d   = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || (i_wait_q == WAIT_LIM))) begin
          state_d     = BUSY_I;
          i_grant_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          i_wait_d    = '0;
        end else if (d_req) begin
          state_d     = BUSY_D;
          d_grant_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_wr_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (i_req && (i_wait_q != WAIT_LIM)) i_wait_d = i_wait_q + 16'd1;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d   = RESP_I;
          i_done_d  = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d  = RESP_D;
          d_done_d = 1'b1;
          if (!mem_wr_q) d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      i_wait_q    <= '0;
      i_grant_q   <= 1'b0;
      d_grant_q   <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      i_wait_q    <= i_wait_d;
      i_grant_q   <= i_grant_d;
      d_grant_q   <= d_grant_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // counters step on the same edge that raises the grant
  sat_counter #(.W(16)) u_i_cnt (.clk(clk), .rst(rst), .en(i_grant_d), .cnt(i_req_cnt));
  sat_counter #(.W(16)) u_d_cnt (.clk(clk), .rst(rst), .en(d_grant_d), .cnt(d_req_cnt));

  assign i_grant   = i_grant_q;
  assign d_grant   = d_grant_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled on the
// falling edge, expectations hand-computed.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, mem_done = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        i_grant, i_done, d_grant, d_done, mem_en, mem_wr;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, i_req_cnt, d_req_cnt;
  int          checks = 0;
  int          failures = 0;
  logic        exp_d;

  mem_arbiter #(.STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .i_req_cnt(i_req_cnt), .d_req_cnt(d_req_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_grant"}, i_grant, 0);
    chk({tag, "_d_grant"}, d_grant, 0);
    chk({tag, "_i_done"}, i_done, 0);
    chk({tag, "_d_done"}, d_done, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_i_cnt"}, i_req_cnt, 0);
    chk({tag, "_d_cnt"}, d_req_cnt, 0);
  endtask

  // grants and dones must never collide
  always @(negedge clk) begin
    if (rst) begin
      chk("excl_grant", {31'd0, i_grant & d_grant}, 0);
      chk("excl_done", {31'd0, i_done & d_done}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(); tick();
    chk_all_zero("rst");
    rst = 1'b1;

    // lone I read, memory answers two cycles after mem_en
    tick();
    i_req = 1'b1; i_addr = 16'h0040;
    tick();                                       // t+1
    chk("t1_i_grant", i_grant, 1);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 16'h0040);
    chk("t1_mem_wr", mem_wr, 0);
    chk("t1_i_cnt", i_req_cnt, 1);
    tick();                                       // t+2
    chk("t1_grant_pulse", i_grant, 0);
    chk("t1_en_pulse", mem_en, 0);
    tick();                                       // t+3
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    tick();                                       // t+4
    mem_done = 1'b0;
    chk("t1_i_done", i_done, 1);
    chk("t1_i_rdata", i_rdata, 16'hBEEF);
    i_req = 1'b0;
    tick();
    chk("t1_done_pulse", i_done, 0);
    chk("t1_rdata_hold", i_rdata, 16'hBEEF);

    // simultaneous I read and D store: D first, I in the following IDLE
    i_req = 1'b1; i_addr = 16'h0080;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    tick();
    chk("t2_d_grant", d_grant, 1);
    chk("t2_i_grant", i_grant, 0);
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_addr", mem_addr, 16'h0100);
    chk("t2_mem_wdata", mem_wdata, 16'h1234);
    chk("t2_d_cnt", d_req_cnt, 1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0;
    chk("t2_d_done", d_done, 1);
    chk("t2_store_rdata", d_rdata, 0);
    d_req = 1'b0; d_wr = 1'b0;
    tick();                                       // IDLE, samples I
    chk("t2_idle_no_grant", i_grant, 0);
    tick();
    chk("t2_i_grant_late", i_grant, 1);
    chk("t2_i_mem_wr", mem_wr, 0);
    chk("t2_i_mem_wdata", mem_wdata, 0);
    chk("t2_i_mem_addr", mem_addr, 16'h0080);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_done = 1'b0;
    chk("t2_i_done", i_done, 1);
    chk("t2_i_rdata", i_rdata, 16'h5555);
    i_req = 1'b0;
    tick();

    // both requesting continuously: D D D D I, then D again
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    for (int n = 0; n < 6; n++) begin
      exp_d = (n != 4);
      tick();
      chk($sformatf("t3_d_grant%0d", n), d_grant, exp_d);
      chk($sformatf("t3_i_grant%0d", n), i_grant, !exp_d);
      tick();
      chk($sformatf("t3_pulse%0d", n), {31'd0, i_grant | d_grant}, 0);
      mem_done = 1'b1; mem_rdata = 16'(16'h0A00 + n);
      tick();
      mem_done = 1'b0;
      if (n == 5) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      tick();
    end
    chk("t3_i_cnt", i_req_cnt, 3);
    chk("t3_d_cnt", d_req_cnt, 6);
    chk("t3_i_rdata", i_rdata, 16'h0A04);
    chk("t3_d_rdata", d_rdata, 16'h0A05);

    // mem_done in IDLE and in the mem_en cycle must be ignored
    mem_done = 1'b1; mem_rdata = 16'h3333;
    tick();
    chk("t5_idle_i_done", i_done, 0);
    chk("t5_idle_d_done", d_done, 0);
    chk("t5_idle_mem_en", mem_en, 0);
    mem_done = 1'b0;
    i_req = 1'b1; i_addr = 16'h0200;
    tick();
    chk("t5_i_grant", i_grant, 1);
    mem_done = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_done = 1'b0;
    chk("t5_early_done", i_done, 0);
    tick();
    chk("t5_still_busy", i_done, 0);
    mem_done = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_done = 1'b0;
    chk("t5_i_done", i_done, 1);
    chk("t5_i_rdata", i_rdata, 16'h2222);
    chk("t5_i_cnt", i_req_cnt, 4);
    i_req = 1'b0;
    tick();

    // d_req_cnt saturation: preload 16'hFFFE, then two D grants
    force dut.u_d_cnt.cnt_q = 16'hFFFE;
    tick();
    release dut.u_d_cnt.cnt_q;
    chk("t4_preload", d_req_cnt, 16'hFFFE);
    for (int n = 0; n < 2; n++) begin
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
      tick();
      chk($sformatf("t4_d_grant%0d", n), d_grant, 1);
      chk($sformatf("t4_d_cnt%0d", n), d_req_cnt, 16'hFFFF);
      tick();
      mem_done = 1'b1; mem_rdata = 16'hCAFE;
      tick();
      mem_done = 1'b0;
      chk($sformatf("t4_d_done%0d", n), d_done, 1);
      d_req = 1'b0;
      tick();
    end
    chk("t4_d_rdata", d_rdata, 16'hCAFE);
    chk("t4_d_cnt_final", d_req_cnt, 16'hFFFF);

    // reset during BUSY_D, stray mem_done afterwards
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'h7777;
    tick();
    chk("t6_d_grant", d_grant, 1);
    tick();
    rst = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    #1;
    chk_all_zero("t6_inrst");
    tick();
    rst = 1'b1;
    tick();
    mem_done = 1'b1; mem_rdata = 16'h9999;
    tick();
    mem_done = 1'b0;
    chk("t6_no_done", d_done, 0);
    chk_all_zero("t6_after");
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    chk("t6_i_grant", i_grant, 1);
    chk("t6_i_cnt", i_req_cnt, 1);
    chk("t6_d_cnt", d_req_cnt, 0);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h4321;
    tick();
    mem_done = 1'b0;
    chk("t6_i_done", i_done, 1);
    chk("t6_i_rdata", i_rdata, 16'h4321);
    i_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
